pin_entry_buffer: RTL and testbench
===================================

# pin_entry_buffer

Keypad front end for the lock system. Assembles four 4-bit key digits into the 16-bit candidate PIN, then issues a single clean `enter` strobe to the lock comparator/attempt counter downstream. The downstream stage samples on the rising edge of `enter`, so `inpin` must be stable before that edge and held after it. The block also handles clear, backspace, short-entry rejection and an inactivity timeout.

## Interface
- `DIGITS`, 4: digits per PIN. `DIGITS*DIGIT_W` must equal 16.
- `DIGIT_W`, 4: bits per key code.
- `TIMEOUT`, 1000: idle cycles before a partial entry is discarded. Must be ≥ 2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  `key_code` is a digit press this cycle.
- `key_code`  in  4  digit value, 0x0–0xF.
- `key_enter`  in  1  submit request, one cycle per press.
- `key_clear`  in  1  discard the current entry.
- `key_back`  in  1  delete the last digit.
- `inpin`  out  16  submitted PIN; changes only at submission.
- `enter`  out  1  one-cycle strobe; `inpin` is valid around it.
- `digit_count`  out  3  digits currently buffered, 0..4.
- `busy`  out  1  submission in progress; all keys are ignored.
- `timeout`  out  1  one-cycle pulse when an entry is discarded by inactivity.
- `short_err`  out  1  one-cycle pulse when enter is pressed with fewer than 4 digits.

## Operation
- Reset values: `inpin`=0, `enter`=0, `digit_count`=0, `busy`=0, `timeout`=0, `short_err`=0. Shift register, idle counter and FSM all clear; FSM goes to ENTRY.
- States: ENTRY, LOAD, STROBE.
- **ENTRY.** Key events are evaluated with priority clear > enter > back > digit. Lower-priority events in the same cycle are dropped.
  - clear: shift register = 0, count = 0.
  - enter with count==4: go to LOAD.
  - enter with count<4: `short_err`=1, shift register = 0, count = 0.
  - back with count>0: shift register >>= 4, count−1. Back with count==0 is ignored.
  - digit with count<4: shift register = {sr[11:0], key_code}, count+1. The first digit entered ends in `inpin[15:12]`.
  - digit with count==4: ignored; the register is unchanged.
- **LOAD** (1 cycle): `inpin` ← shift register, `busy`=1. Next state STROBE.
- **STROBE** (1 cycle): `enter`=1, `busy`=1. Shift register and count clear. Next state ENTRY.
- Idle counter, width $clog2(TIMEOUT):
  - Resets to 0 on any accepted or ignored key event, and whenever count==0.
  - Otherwise increments each ENTRY cycle.
  - If count>0, the counter equals TIMEOUT−1 and no key event occurs: next edge clears the shift register, count and counter, and pulses `timeout`=1.
  - A key event in that same cycle wins and no timeout occurs.
- Keys asserted during LOAD/STROBE are dropped, not queued.
- `reset` mid-submission aborts it. No `enter` is emitted and `inpin` returns to 0.

## Timing
- Enter accepted at edge N: `busy`=1 after N+1, with `inpin` updated at that same edge. `enter`=1 after N+2; `enter`=0 and `busy`=0 after N+3.
- `inpin` is therefore stable for at least one full cycle before the `enter` rising edge and holds until the next submission.
- The earliest next key acceptance is in the cycle following N+3.
- All outputs are registered; no combinational path runs from inputs to outputs.
- `timeout` is asserted exactly TIMEOUT cycles after the edge of the last key event, when the entry is non-empty.
- `short_err` and `timeout` are 1-cycle pulses registered with the state change.

## Test plan
- Reset, then digits 1,2,3,4 and enter. Expect `busy` high 2 cycles, `inpin`=0x1234 one cycle before a single 1-cycle `enter`, then `digit_count`=0.
- Digits A,B,C,D,E, then enter. Expect E ignored, `digit_count` stays 4, `inpin`=0xABCD.
- Digits 5,6, back, 7,8,9, enter. Expect `inpin`=0x5789. Back at count 0 leaves count at 0.
- Digits 1,2 then enter. Expect `short_err` pulse, `digit_count`=0, no `enter`, `inpin` unchanged. Then assert clear and enter together with 4 digits buffered: clear wins, no `enter`.
- TIMEOUT=8: digit 3, then idle. Expect a `timeout` pulse exactly 8 cycles after the key edge and `digit_count`=0. A key on cycle 7 cancels the timeout.
- Assert `reset` in the LOAD cycle. Expect no `enter`, `inpin`=0, `busy`=0 next cycle. Keys pressed during STROBE are not captured.

Source files
------------

// File: rtl/pin_entry_buffer.sv
// Keypad PIN entry front end: collects digits into a candidate PIN, then
// presents it to the lock comparator with a clean, pre-settled enter strobe.
// Also handles clear, backspace, short-entry rejection and inactivity timeout.
module pin_entry_buffer #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        key_valid,
  input  logic [DIGIT_W-1:0]          key_code,
  input  logic                        key_enter,
  input  logic                        key_clear,
  input  logic                        key_back,
  output logic [DIGITS*DIGIT_W-1:0]   inpin,
  output logic                        enter,
  output logic [2:0]                  digit_count,
  output logic                        busy,
  output logic                        timeout,
  output logic                        short_err
);

  localparam int unsigned PIN_W  = DIGITS * DIGIT_W;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT);
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PIN_W-1:0]   sr_q, sr_d;
  logic [PIN_W-1:0]   inpin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               enter_d, busy_d, timeout_d, short_err_d;
  logic               key_any, accept, full, expired;

  // Key events are only honoured in ENTRY once the previous strobe has retired
  assign key_any = key_valid | key_enter | key_clear | key_back;
  assign accept  = (state_q == ENTRY) && !busy;
  assign full    = (cnt_q == CNT_W'(DIGITS));
  assign expired = (cnt_q != '0) && (idle_q == IDLE_W'(TIMEOUT - 1));

  assign digit_count = cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a full entry plus enter (not overridden by clear) submits
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENTRY:   if (accept && !key_clear && key_enter && full) state_d = LOAD;
      LOAD:    state_d = STROBE;
      STROBE:  state_d = ENTRY;
      default: state_d = ENTRY;
    endcase
  end

  // Datapath and output next values; clear > enter > back > digit
  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    idle_d      = '0;
    inpin_d     = inpin;
    enter_d     = 1'b0;
    busy_d      = 1'b0;
    timeout_d   = 1'b0;
    short_err_d = 1'b0;
    case (state_q)
      ENTRY: begin
        if (accept) begin
          if (key_any) begin
            if (key_clear) begin
              sr_d  = '0;
              cnt_d = '0;
            end else if (key_enter) begin
              if (!full) begin
                short_err_d = 1'b1;
                sr_d        = '0;
                cnt_d       = '0;
              end
            end else if (key_back) begin
              if (cnt_q != '0) begin
                sr_d  = sr_q >> DIGIT_W;
                cnt_d = cnt_q - CNT_W'(1);
              end
            end else if (!full) begin
              sr_d  = {sr_q[PIN_W-DIGIT_W-1:0], key_code};
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (expired) begin
            timeout_d = 1'b1;
            sr_d      = '0;
            cnt_d     = '0;
          end else if (cnt_q != '0) begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      LOAD: begin
        inpin_d = sr_q;
        busy_d  = 1'b1;
      end
      STROBE: begin
        enter_d = 1'b1;
        busy_d  = 1'b1;
        sr_d    = '0;
        cnt_d   = '0;
      end
      default: begin
        sr_d  = '0;
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      inpin     <= '0;
      enter     <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      short_err <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      inpin     <= inpin_d;
      enter     <= enter_d;
      busy      <= busy_d;
      timeout   <= timeout_d;
      short_err <= short_err_d;
    end
  end

endmodule

// File: tb/tb_pin_entry_buffer.sv
// Bench for pin_entry_buffer: directed scenarios with literal expectations,
// then randomized key traffic compared every cycle against a digit-queue model.
module tb_pin_entry_buffer;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_enter;
  logic        key_clear;
  logic        key_back;
  logic [15:0] inpin;
  logic        enter;
  logic [2:0]  digit_count;
  logic        busy;
  logic        timeout;
  logic        short_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  pin_entry_buffer #(
    .DIGITS (4),
    .DIGIT_W(4),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_enter  (key_enter),
    .key_clear  (key_clear),
    .key_back   (key_back),
    .inpin      (inpin),
    .enter      (enter),
    .digit_count(digit_count),
    .busy       (busy),
    .timeout    (timeout),
    .short_err  (short_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the entry is a queue of digits; a submission is a
  // three-edge sequence after acceptance; idle time counts edges since a key.
  int unsigned digs[$];
  int          sub_phase = 0;
  int          idle      = 0;
  logic [15:0] m_pin     = '0;
  logic [15:0] m_inpin   = '0;
  logic        m_enter   = 1'b0;
  logic        m_busy    = 1'b0;
  logic        m_to      = 1'b0;
  logic        m_short   = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      m_to    = 1'b0;
      m_short = 1'b0;
      if (reset) begin
        digs.delete();
        sub_phase = 0;
        idle      = 0;
        m_inpin   = '0;
        m_enter   = 1'b0;
        m_busy    = 1'b0;
      end else if (sub_phase == 1) begin
        m_inpin   = m_pin;
        m_busy    = 1'b1;
        sub_phase = 2;
      end else if (sub_phase == 2) begin
        m_enter   = 1'b1;
        digs.delete();
        sub_phase = 3;
      end else if (sub_phase == 3) begin
        m_enter   = 1'b0;
        m_busy    = 1'b0;
        sub_phase = 0;
      end else if (key_clear || key_enter || key_back || key_valid) begin
        idle = 0;
        if (key_clear) begin
          digs.delete();
        end else if (key_enter) begin
          if (digs.size() == 4) begin
            m_pin = 16'(digs[0] * 4096 + digs[1] * 256 + digs[2] * 16 + digs[3]);
            sub_phase = 1;
          end else begin
            m_short = 1'b1;
            digs.delete();
          end
        end else if (key_back) begin
          if (digs.size() > 0) void'(digs.pop_back());
        end else if (digs.size() < 4) begin
          digs.push_back(32'(key_code));
        end
      end else if (digs.size() == 0) begin
        idle = 0;
      end else begin
        idle++;
        if (idle == int'(TO)) begin
          m_to = 1'b1;
          digs.delete();
          idle = 0;
        end
      end
    end
  end

  // Compare DUT outputs against the model mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("inpin",       32'(inpin),       32'(m_inpin));
        chk("enter",       32'(enter),       32'(m_enter));
        chk("digit_count", 32'(digit_count), 32'(digs.size()));
        chk("busy",        32'(busy),        32'(m_busy));
        chk("timeout",     32'(timeout),     32'(m_to));
        chk("short_err",   32'(short_err),   32'(m_short));
      end
    end
  end

  // Apply one cycle of inputs from a negedge; returns at the next negedge
  task automatic drive(input logic v, input logic [3:0] c, input logic e,
                       input logic cl, input logic b);
    key_valid = v;
    key_code  = c;
    key_enter = e;
    key_clear = cl;
    key_back  = b;
    @(negedge clk);
    key_valid = 1'b0;
    key_enter = 1'b0;
    key_clear = 1'b0;
    key_back  = 1'b0;
  endtask

  task automatic dig(input logic [3:0] c);
    drive(1'b1, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int quiet;
    quiet     = 0;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    key_enter = 1'b0;
    key_clear = 1'b0;
    key_back  = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_inpin", 32'(inpin), 32'h0);
    chk("rst_enter", 32'(enter), 32'h0);
    chk("rst_count", 32'(digit_count), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_to",    32'(timeout), 32'h0);
    chk("rst_short", 32'(short_err), 32'h0);

    // Basic submission 1,2,3,4
    dig(4'h1); dig(4'h2); dig(4'h3); dig(4'h4);
    chk("s1_count4", 32'(digit_count), 32'd4);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("s1_load_busy", 32'(busy), 32'h0);
    idle_n(1);
    chk("s1_busy1",  32'(busy),  32'h1);
    chk("s1_pin",    32'(inpin), 32'h1234);
    chk("s1_noent",  32'(enter), 32'h0);
    idle_n(1);
    chk("s1_enter",  32'(enter), 32'h1);
    chk("s1_busy2",  32'(busy),  32'h1);
    chk("s1_cnt0",   32'(digit_count), 32'h0);
    idle_n(1);
    chk("s1_enter_lo", 32'(enter), 32'h0);
    chk("s1_busy_lo",  32'(busy),  32'h0);

    // Fifth digit ignored
    dig(4'hA); dig(4'hB); dig(4'hC); dig(4'hD); dig(4'hE);
    chk("s2_count4", 32'(digit_count), 32'd4);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle_n(2);
    chk("s2_pin", 32'(inpin), 32'hABCD);
    idle_n(2);

    // Backspace
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("s3_back0", 32'(digit_count), 32'd0);
    dig(4'h5); dig(4'h6);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("s3_back1", 32'(digit_count), 32'd1);
    dig(4'h7); dig(4'h8); dig(4'h9);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle_n(2);
    chk("s3_pin", 32'(inpin), 32'h5789);
    idle_n(2);

    // Short entry, then clear beats enter
    dig(4'h1); dig(4'h2);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("s4_short",  32'(short_err), 32'h1);
    chk("s4_cnt0",   32'(digit_count), 32'd0);
    chk("s4_busy",   32'(busy), 32'h0);
    idle_n(1);
    chk("s4_short_lo", 32'(short_err), 32'h0);
    chk("s4_pin",    32'(inpin), 32'h5789);
    dig(4'h1); dig(4'h2); dig(4'h3); dig(4'h4);
    drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("s4_clr_cnt",   32'(digit_count), 32'd0);
    chk("s4_clr_short", 32'(short_err), 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle_n(1);
      chk("s4_clr_noent", 32'(enter), 32'h0);
      chk("s4_clr_nobusy", 32'(busy), 32'h0);
    end

    // Inactivity timeout exactly TO edges after the key
    dig(4'h3);
    for (int i = 1; i < int'(TO); i++) begin
      idle_n(1);
      chk("s5_no_to", 32'(timeout), 32'h0);
    end
    idle_n(1);
    chk("s5_to",     32'(timeout), 32'h1);
    chk("s5_to_cnt", 32'(digit_count), 32'd0);
    idle_n(1);
    chk("s5_to_lo",  32'(timeout), 32'h0);
    // Key in the last idle cycle cancels the timeout
    dig(4'h3);
    idle_n(int'(TO) - 1);
    dig(4'h4);
    chk("s5_cancel_to",  32'(timeout), 32'h0);
    chk("s5_cancel_cnt", 32'(digit_count), 32'd2);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Reset during LOAD aborts the submission
    dig(4'h4); dig(4'h3); dig(4'h2); dig(4'h1);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s6_rst_pin",  32'(inpin), 32'h0);
    chk("s6_rst_busy", 32'(busy), 32'h0);
    chk("s6_rst_ent",  32'(enter), 32'h0);
    for (int i = 0; i < 2; i++) begin
      idle_n(1);
      chk("s6_rst_noent", 32'(enter), 32'h0);
    end
    // Keys during STROBE and the enter cycle are dropped
    dig(4'h1); dig(4'h1); dig(4'h1); dig(4'h1);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle_n(1);
    chk("s6_busy", 32'(busy), 32'h1);
    dig(4'h9);
    chk("s6_ent",      32'(enter), 32'h1);
    chk("s6_strobe_cnt", 32'(digit_count), 32'd0);
    drive(1'b1, 4'h9, 1'b0, 1'b0, 1'b1);
    chk("s6_busy_cnt", 32'(digit_count), 32'd0);
    chk("s6_pin",      32'(inpin), 32'h1111);
    dig(4'h7);
    chk("s6_next_key", 32'(digit_count), 32'd1);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if (quiet > 0) begin
        quiet--;
        reset     = 1'b0;
        key_valid = 1'b0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        key_back  = 1'b0;
      end else begin
        reset     = ($urandom_range(0, 299) == 0);
        key_valid = ($urandom_range(0, 2) == 0);
        key_enter = ($urandom_range(0, 9) == 0);
        key_clear = ($urandom_range(0, 39) == 0);
        key_back  = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 24) == 0) quiet = int'($urandom_range(4, 12));
      end
      key_code = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    reset     = 1'b0;
    key_valid = 1'b0;
    key_enter = 1'b0;
    key_clear = 1'b0;
    key_back  = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
